// File: rtl/ttt_board_engine.sv
// Tic-tac-toe board engine: stores the 3x3 board, commits player and computer moves,
// and reports illegal-move, board-full and winner status back to the game FSM.
module ttt_board_engine #(
    parameter logic [3:0] SEED       = 4'd1,
    parameter bit         WIN_FREEZE = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        player_play,
    input  logic        computer_play,
    input  logic [3:0]  player_position,
    output logic        illegal_move,
    output logic        no_space,
    output logic        win,
    output logic [1:0]  who,
    output logic [17:0] board,
    output logic [3:0]  computer_position
);

    logic [17:0] r_board;
    logic        r_win;
    logic [1:0]  r_who;
    logic        r_no_space;
    logic [3:0]  r_comp_pos;
    logic [3:0]  r_ptr;

    logic [15:0] w_occ;
    logic [17:0] w_board_next;
    logic        w_frozen;
    logic        w_player_we;
    logic        w_comp_we;
    logic [3:0]  w_start;
    logic [3:0]  w_cand [0:8];
    logic [8:0]  w_cand_empty;
    logic        w_pick_valid;
    logic [3:0]  w_pick;
    logic [7:0]  w_line_p;
    logic [7:0]  w_line_c;
    logic [3:0]  w_ptr_next;

    // Occupancy indexed directly by cell number; index 0 and 10..15 read as
    // occupied so illegal_move becomes a single lookup.
    assign w_occ[0]     = 1'b1;
    assign w_occ[15:10] = 6'b111111;

    genvar gi;
    generate
        for (gi = 1; gi <= 9; gi++) begin : g_occ
            assign w_occ[gi] = |r_board[2*gi-1 -: 2];
        end
    endgenerate

    assign illegal_move = w_occ[player_position];
    assign w_frozen     = WIN_FREEZE & r_win;
    assign w_player_we  = player_play & ~illegal_move & ~w_frozen;
    assign w_start      = (r_ptr >= 4'd1 && r_ptr <= 4'd9) ? r_ptr : 4'd1;

    // Scan candidates: offset k from the pointer, wrapping 9 -> 1.
    generate
        for (gi = 0; gi <= 8; gi++) begin : g_scan
            logic [4:0] w_sum;
            assign w_sum            = {1'b0, w_start} + 5'(gi);
            assign w_cand[gi]       = (w_sum > 5'd9) ? 4'(w_sum - 5'd9) : w_sum[3:0];
            assign w_cand_empty[gi] = ~w_occ[w_cand[gi]];
        end
    endgenerate

    always_comb begin
        w_pick_valid = 1'b0;
        w_pick       = 4'd0;
        for (int k = 8; k >= 0; k--) begin
            if (w_cand_empty[k]) begin
                w_pick_valid = 1'b1;
                w_pick       = w_cand[k];
            end
        end
    end

    assign w_comp_we = computer_play & ~player_play & ~w_frozen & w_pick_valid;

    generate
        for (gi = 1; gi <= 9; gi++) begin : g_cell
            assign w_board_next[2*gi-1 -: 2] =
                (w_player_we && player_position == 4'(gi)) ? 2'b01 :
                (w_comp_we   && w_pick          == 4'(gi)) ? 2'b10 :
                r_board[2*gi-1 -: 2];
        end
    endgenerate

    // Lines 0-2 rows, 3-5 columns, 6 main diagonal, 7 anti-diagonal.
    generate
        for (gi = 0; gi < 8; gi++) begin : g_line
            localparam int A = (gi < 3) ? 3*gi + 1 : (gi < 6) ? gi - 2 : (gi == 6) ? 1 : 3;
            localparam int S = (gi < 3) ? 1 : (gi < 6) ? 3 : (gi == 6) ? 4 : 2;
            assign w_line_p[gi] = (r_board[2*A-1 -: 2]       == 2'b01) &&
                                  (r_board[2*(A+S)-1 -: 2]   == 2'b01) &&
                                  (r_board[2*(A+2*S)-1 -: 2] == 2'b01);
            assign w_line_c[gi] = (r_board[2*A-1 -: 2]       == 2'b10) &&
                                  (r_board[2*(A+S)-1 -: 2]   == 2'b10) &&
                                  (r_board[2*(A+2*S)-1 -: 2] == 2'b10);
        end
    endgenerate

    assign w_ptr_next = (r_ptr >= 4'd1 && r_ptr <= 4'd8) ? r_ptr + 4'd1 : 4'd1;

    // Status is taken from the registered board, so it trails the write by one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_board    <= 18'd0;
            r_win      <= 1'b0;
            r_who      <= 2'b00;
            r_no_space <= 1'b0;
            r_comp_pos <= 4'd0;
            r_ptr      <= SEED;
        end else begin
            r_board    <= w_board_next;
            r_ptr      <= w_ptr_next;
            r_no_space <= &w_occ[9:1];
            if (w_comp_we) begin
                r_comp_pos <= w_pick;
            end
            if (!r_win) begin
                r_win <= (|w_line_p) | (|w_line_c);
                r_who <= (|w_line_p) ? 2'b01 : (|w_line_c) ? 2'b10 : 2'b00;
            end
        end
    end

    assign board             = r_board;
    assign win               = r_win;
    assign who               = r_who;
    assign no_space          = r_no_space;
    assign computer_position = r_comp_pos;

endmodule

// File: tb/tb_ttt_board_engine.sv
// Self-checking bench for ttt_board_engine: a game-level board model checked every
// cycle, plus hand-computed board values at key points of each directed scenario.
module tb_ttt_board_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pp  = 1'b0;
    logic        cp  = 1'b0;
    logic [3:0]  pos = 4'd0;
    logic        illegal_move;
    logic        no_space;
    logic        win;
    logic [1:0]  who;
    logic [17:0] board;
    logic [3:0]  computer_position;

    int checks = 0;
    int errors = 0;

    ttt_board_engine #(.SEED(4'd1), .WIN_FREEZE(1'b1)) dut (
        .clock             (clk),
        .reset             (rst),
        .player_play       (pp),
        .computer_play     (cp),
        .player_position   (pos),
        .illegal_move      (illegal_move),
        .no_space          (no_space),
        .win               (win),
        .who               (who),
        .board             (board),
        .computer_position (computer_position)
    );

    always #5 clk = ~clk;

    // Game-level model
    logic [1:0] m_cell [1:9];
    int         m_ptr;
    bit         m_win;
    logic [1:0] m_who;
    bit         m_full;
    int         m_cpos;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit has_line(input logic [1:0] owner);
        int ln [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                          '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};
        for (int l = 0; l < 8; l++)
            if (m_cell[ln[l][0]] == owner && m_cell[ln[l][1]] == owner && m_cell[ln[l][2]] == owner)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [17:0] m_board();
        logic [17:0] b = '0;
        for (int i = 1; i <= 9; i++) b[2*i-2 +: 2] = m_cell[i];
        return b;
    endfunction

    function automatic bit m_illegal();
        if (pos == 4'd0 || pos > 4'd9) return 1'b1;
        return m_cell[pos] != 2'b00;
    endfunction

    task automatic model_reset();
        for (int i = 1; i <= 9; i++) m_cell[i] = 2'b00;
        m_ptr = 1; m_win = 0; m_who = 2'b00; m_full = 0; m_cpos = 0;
    endtask

    task automatic model_edge();
        bit wp, wc, full_now;
        int start, pick, c;
        wp = has_line(2'b01);
        wc = has_line(2'b10);
        full_now = 1;
        for (int i = 1; i <= 9; i++) if (m_cell[i] == 2'b00) full_now = 0;
        if (!m_win) begin
            if (pp && !m_illegal()) begin
                m_cell[pos] = 2'b01;
            end else if (cp && !pp) begin
                start = (m_ptr >= 1 && m_ptr <= 9) ? m_ptr : 1;
                pick = 0;
                for (int k = 0; k < 9; k++) begin
                    c = (start - 1 + k) % 9 + 1;
                    if (pick == 0 && m_cell[c] == 2'b00) pick = c;
                end
                if (pick != 0) begin
                    m_cell[pick] = 2'b10;
                    m_cpos = pick;
                end
            end
        end
        m_full = full_now;
        if (!m_win) begin
            m_win = wp || wc;
            m_who = wp ? 2'b01 : (wc ? 2'b10 : 2'b00);
        end
        m_ptr = (m_ptr >= 1 && m_ptr <= 8) ? m_ptr + 1 : 1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_edge();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("board",   32'(board),             32'(m_board()));
            check("win",     32'(win),               32'(m_win));
            check("who",     32'(who),               32'(m_who));
            check("nospace", 32'(no_space),          32'(m_full));
            check("cpos",    32'(computer_position), 32'(m_cpos));
            check("illegal", 32'(illegal_move),      32'(m_illegal()));
        end
    end

    task automatic step(input bit p, input bit c, input logic [3:0] q);
        pp = p; cp = c; pos = q;
        @(posedge clk); #1;
        pp = 0; cp = 0;
    endtask

    task automatic do_reset();
        rst = 1; pp = 0; cp = 0; pos = 4'd0;
        #1;
        check("rst_board",   32'(board),             32'h0);
        check("rst_win",     32'(win),               32'h0);
        check("rst_who",     32'(who),               32'h0);
        check("rst_nospace", 32'(no_space),          32'h0);
        check("rst_cpos",    32'(computer_position), 32'h0);
        check("rst_illegal", 32'(illegal_move),      32'h1);
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic wait_ptr(input int v);
        for (int i = 0; i < 12 && m_ptr != v; i++) step(0, 0, pos);
        if (m_ptr != v) begin
            checks++; errors++;
            $display("FAIL ptr_wait: actual=%0d required=%0d", m_ptr, v);
        end
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();

        // Illegal-move decode
        pos = 4'd5; #1;  check("ill_pos5_empty", 32'(illegal_move), 32'h0);
        pos = 4'd10; #1; check("ill_pos10",      32'(illegal_move), 32'h1);

        // Player move at centre, then re-present it
        step(1, 0, 4'd5);
        check("p5_board", 32'(board), 32'h100);
        #1; check("ill_pos5_taken", 32'(illegal_move), 32'h1);
        step(1, 0, 4'd5);
        check("p5_again_board", 32'(board), 32'h100);
        step(1, 0, 4'd12);
        check("p12_board", 32'(board), 32'h100);

        // Computer scan from pointer 1 with cells 1,2 taken
        do_reset();
        step(1, 0, 4'd1);
        step(1, 0, 4'd2);
        wait_ptr(1);
        step(0, 1, 4'd0);
        check("c_ptr1_board", 32'(board), 32'h25);
        check("c_ptr1_cpos",  32'(computer_position), 32'h3);

        // Computer scan from pointer 8 wrapping past full 8,9,1
        do_reset();
        step(1, 0, 4'd8);
        step(1, 0, 4'd9);
        step(1, 0, 4'd1);
        wait_ptr(8);
        step(0, 1, 4'd0);
        check("c_ptr8_board", 32'(board), 32'h14009);
        check("c_ptr8_cpos",  32'(computer_position), 32'h2);

        // Top-row win, lagged status, then freeze
        do_reset();
        step(1, 0, 4'd1);
        step(1, 0, 4'd2);
        step(1, 0, 4'd3);
        check("win_lag", 32'(win), 32'h0);
        step(0, 0, 4'd0);
        check("win_set", 32'(win), 32'h1);
        check("win_who", 32'(who), 32'h1);
        step(1, 0, 4'd5);
        check("frz_player", 32'(board), 32'h15);
        step(0, 1, 4'd0);
        check("frz_comp",   32'(board), 32'h15);

        // Draw: O on 2,5,6,7 then X on 1,3,4,8 and finally 9
        do_reset();
        wait_ptr(2); step(0, 1, 4'd0);
        wait_ptr(5); step(0, 1, 4'd0);
        step(0, 1, 4'd0);
        step(0, 1, 4'd0);
        step(1, 0, 4'd1);
        step(1, 0, 4'd3);
        step(1, 0, 4'd4);
        step(1, 0, 4'd8);
        step(1, 0, 4'd9);
        check("draw_board", 32'(board), 32'h16A59);
        step(0, 0, 4'd9);
        check("draw_nospace", 32'(no_space), 32'h1);
        check("draw_win",     32'(win),      32'h0);
        step(0, 1, 4'd0);
        check("full_comp_board", 32'(board), 32'h16A59);
        check("full_comp_cpos",  32'(computer_position), 32'h7);

        // Simultaneous requests: player wins
        do_reset();
        step(1, 1, 4'd4);
        check("both_board", 32'(board), 32'h40);
        check("both_cpos",  32'(computer_position), 32'h0);

        // Mid-game reset with a move held during the reset edge
        step(0, 1, 4'd0);
        rst = 1; pp = 1; pos = 4'd1;
        #1;
        check("mid_rst_board", 32'(board), 32'h0);
        check("mid_rst_cpos",  32'(computer_position), 32'h0);
        @(posedge clk); #1;
        pp = 0; rst = 0;
        check("mid_rst_discard", 32'(board), 32'h0);
        step(0, 0, 4'd0);

        @(negedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
